// File: rtl/regfile_bypass.sv
// Register file: two combinational read ports with optional same-cycle write
// forwarding, an optional hardwired zero register and a sequential clear sweep.
module regfile_bypass #(
  parameter int N        = 64,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  D,
  input  logic [AW-1:0] DA,
  input  logic          write,
  input  logic [AW-1:0] SA,
  input  logic [AW-1:0] SB,
  input  logic          clear,
  output logic [N-1:0]  A,
  output logic [N-1:0]  B,
  output logic          busy,
  output logic          wr_drop
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] LAST = '1;

  typedef enum logic {
    IDLE,
    SWEEP
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          wr_drop_q, wr_drop_d;
  logic [N-1:0]  mem_q [DEPTH];
  logic [N-1:0]  mem_d [DEPTH];

  logic wr_zero;
  logic fwd;

  assign wr_zero = (ZERO_REG != 0) && (DA == LAST);
  assign fwd = (BYPASS != 0) && !busy_q && write
             && !clear && !wr_zero;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    wr_drop_d = 1'b0;
    mem_d     = mem_q;
    if (reset) begin
      state_d = IDLE;
      cnt_d   = '0;
      busy_d  = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = '0;
      end
    end else begin
      // A write loses to an active sweep or to a clear in the same cycle.
      wr_drop_d = write && (busy_q || clear);
      unique case (state_q)
        IDLE: begin
          if (clear) begin
            state_d = SWEEP;
            cnt_d   = '0;
            busy_d  = 1'b1;
          end else if (write && !wr_zero) begin
            mem_d[DA] = D;
          end
        end
        SWEEP: begin
          mem_d[cnt_q] = '0;
          cnt_d        = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    state_q   <= state_d;
    cnt_q     <= cnt_d;
    busy_q    <= busy_d;
    wr_drop_q <= wr_drop_d;
    mem_q     <= mem_d;
  end

  always_comb begin
    A = mem_q[SA];
    B = mem_q[SB];
    if (fwd && (SA == DA)) A = D;
    if (fwd && (SB == DA)) B = D;
    if ((ZERO_REG != 0) && (SA == LAST)) A = '0;
    if ((ZERO_REG != 0) && (SB == LAST)) B = '0;
    if (busy_q) begin
      A = '0;
      B = '0;
    end
  end

  assign busy    = busy_q;
  assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_regfile_bypass.sv
// Bench for regfile_bypass: one forwarding and one non-forwarding instance
// share stimulus and are checked every cycle against a behavioural model.
module tb_regfile_bypass;

  logic        clock = 1'b0;
  logic        reset, write, clear;
  logic [63:0] D;
  logic [4:0]  DA, SA, SB;
  logic [63:0] A1, B1, A0, B0;
  logic        busy1, drop1, busy0, drop0;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  always #5 clock = ~clock;

  regfile_bypass #(.BYPASS(1)) dut1 (
    .clock(clock), .reset(reset), .D(D), .DA(DA),
    .write(write), .SA(SA), .SB(SB), .clear(clear),
    .A(A1), .B(B1), .busy(busy1), .wr_drop(drop1)
  );

  regfile_bypass #(.BYPASS(0)) dut0 (
    .clock(clock), .reset(reset), .D(D), .DA(DA),
    .write(write), .SA(SA), .SB(SB), .clear(clear),
    .A(A0), .B(B0), .busy(busy0), .wr_drop(drop0)
  );

  // Model: a clear wipes everything at once and then blanks reads for
  // 32 cycles; externally that is indistinguishable from the sweep.
  logic [63:0] m_mem [32];
  int          m_busy_left = 0;
  bit          m_drop = 0;

  always @(posedge clock) begin
    if (reset) begin
      foreach (m_mem[i]) m_mem[i] = '0;
      m_busy_left = 0;
      m_drop = 0;
    end else begin
      m_drop = write && (m_busy_left > 0 || clear);
      if (m_busy_left > 0) m_busy_left--;
      else if (clear) begin
        foreach (m_mem[i]) m_mem[i] = '0;
        m_busy_left = 32;
      end else if (write && DA != 5'd31) m_mem[DA] = D;
    end
  end

  function automatic logic [63:0] exp_rd(input logic [4:0] sel, input bit byp);
    if (m_busy_left > 0) return '0;
    if (sel == 5'd31) return '0;
    if (byp && write && !clear && sel == DA) return D;
    return m_mem[sel];
  endfunction

  task automatic cmp(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      cmp("m_a_byp", A1, exp_rd(SA, 1));
      cmp("m_b_byp", B1, exp_rd(SB, 1));
      cmp("m_a_nobyp", A0, exp_rd(SA, 0));
      cmp("m_b_nobyp", B0, exp_rd(SB, 0));
      cmp("m_busy1", {63'd0, busy1}, {63'd0, m_busy_left > 0});
      cmp("m_busy0", {63'd0, busy0}, {63'd0, m_busy_left > 0});
      cmp("m_drop1", {63'd0, drop1}, {63'd0, m_drop});
      cmp("m_drop0", {63'd0, drop0}, {63'd0, m_drop});
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic look();
    @(negedge clock);
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      tick();
      SA = 5'(i);
      SB = 5'(31 - i);
      look();
      cmp({tag, "_a"}, A1, 64'd0);
      cmp({tag, "_b"}, B0, 64'd0);
    end
  endtask

  int  n;
  bit  done;

  initial begin
    reset = 1; write = 0; clear = 0;
    D = '0; DA = '0; SA = '0; SB = '0;
    tick();
    chk_en = 1;
    tick();
    reset = 0;
    look();
    cmp("rst_busy", {63'd0, busy1}, 64'd0);
    cmp("rst_drop", {63'd0, drop1}, 64'd0);
    cmp("rst_a", A1, 64'd0);

    tick();
    write = 1; DA = 3; D = 64'hDEADBEEF_CAFEF00D; SA = 3; SB = 31;
    look();
    cmp("fwd3_a", A1, 64'hDEADBEEF_CAFEF00D);
    cmp("nofwd3_a", A0, 64'd0);
    tick();
    write = 0;
    look();
    cmp("rd3_a", A1, 64'hDEADBEEF_CAFEF00D);
    cmp("rd31_b", B1, 64'd0);
    cmp("rd3_a_nobyp", A0, 64'hDEADBEEF_CAFEF00D);

    tick();
    write = 1; DA = 7; SA = 7; D = 64'h1234;
    look();
    cmp("fwd7_a", A1, 64'h1234);
    cmp("nofwd7_a", A0, 64'd0);
    tick();
    write = 0;
    look();
    cmp("rd7_a_nobyp", A0, 64'h1234);

    tick();
    write = 1; DA = 31; SA = 31; D = 64'hFFFF;
    look();
    cmp("zero_fwd_a", A1, 64'd0);
    tick();
    write = 0;
    look();
    cmp("zero_rd_a", A1, 64'd0);
    cmp("zero_drop", {63'd0, drop1}, 64'd0);

    tick();
    clear = 1; SA = 3; SB = 7;
    tick();
    clear = 0;
    n = 0;
    done = 0;
    for (int k = 0; k < 100; k++) begin
      look();
      if (!busy1) begin
        done = 1;
        break;
      end
      n++;
      cmp("sweep_a", A1, 64'd0);
      cmp("sweep_b", B1, 64'd0);
      if (n == 7) cmp("sweep_drop_hi", {63'd0, drop1}, 64'd1);
      if (n == 8) cmp("sweep_drop_lo", {63'd0, drop1}, 64'd0);
      tick();
      write = (n == 5); DA = 3; D = 64'h5555;
      clear = (n == 8);
    end
    write = 0; clear = 0;
    cmp("sweep_done", {63'd0, done}, 64'd1);
    cmp("sweep_len", 64'(n), 64'd32);
    read_all_zero("post_sweep");

    tick();
    write = 1; DA = 5; D = 64'hAAAA; SA = 5;
    tick();
    clear = 1; write = 1; D = 64'hBBBB;
    look();
    cmp("clrwr_old_a", A1, 64'hAAAA);
    tick();
    clear = 0; write = 0;
    look();
    cmp("clrwr_drop_hi", {63'd0, drop1}, 64'd1);
    cmp("clrwr_busy", {63'd0, busy1}, 64'd1);
    tick();
    look();
    cmp("clrwr_drop_lo", {63'd0, drop1}, 64'd0);
    done = 0;
    for (int k = 0; k < 100; k++) begin
      look();
      if (!busy1) begin
        done = 1;
        break;
      end
    end
    cmp("clrwr_done", {63'd0, done}, 64'd1);

    tick();
    write = 1; DA = 9; D = 64'h99; SA = 9;
    tick();
    write = 0;
    look();
    cmp("rd9_a", A1, 64'h99);
    tick();
    clear = 1;
    tick();
    clear = 0;
    repeat (9) tick();
    reset = 1; write = 1; DA = 9; D = 64'h77;
    tick();
    reset = 0; write = 0;
    look();
    cmp("abort_busy", {63'd0, busy1}, 64'd0);
    cmp("abort_drop", {63'd0, drop1}, 64'd0);
    read_all_zero("post_abort");

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_bypass.md
REGFILE_BYPASS -- requirements
Module: regfile_bypass

Interface
REQ-001 SHALL have parameter N, default 64: data width in bits.
REQ-002 SHALL have parameter AW, default 5: address width; depth = 2^AW registers.
REQ-003 SHALL have parameter ZERO_REG, default 1: when 1, register 2^AW-1 is hardwired to zero.
REQ-004 SHALL have parameter BYPASS, default 1: when 1, same-cycle write data is forwarded to the read ports.
REQ-005 SHALL have port clock, input, 1: single clock; all state updates on its posedge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port D, input, N: write data.
REQ-008 SHALL have port DA, input, AW: write address.
REQ-009 SHALL have port write, input, 1: write enable.
REQ-010 SHALL have port SA, input, AW: read address for port A.
REQ-011 SHALL have port SB, input, AW: read address for port B.
REQ-012 SHALL have port clear, input, 1: single-cycle request to start a sweep that zeroes all registers.
REQ-013 SHALL have port A, output, N: read data, port A.
REQ-014 SHALL have port B, output, N: read data, port B.
REQ-015 SHALL have port busy, output, 1: a clear sweep is in progress.
REQ-016 SHALL have port wr_drop, output, 1: registered pulse indicating the previous cycle's write was discarded.

Function
REQ-017 SHALL read combinationally: A = reg[SA] and B = reg[SB], with no added latency when idle.
REQ-018 SHALL, on posedge with write=1, busy=0, clear=0 and reset=0, load D into reg[DA]; the new value is visible on A/B in the following cycle.
REQ-019 SHALL, when ZERO_REG=1, ignore writes to index 2^AW-1 without setting wr_drop; that index always reads 0, including through the bypass path.
REQ-020 SHALL, when BYPASS=1, busy=0, write=1, clear=0 and SA==DA (not the zero register), drive A = D in the same cycle; B behaves the same way with SB.
REQ-021 SHALL, when BYPASS=0, never forward: A/B show the old contents until the next cycle.
REQ-022 SHALL implement a 2-state FSM, IDLE and SWEEP, with an AW-bit sweep counter cnt.
REQ-023 SHALL move IDLE->SWEEP on posedge with clear=1, setting cnt=0 and busy=1.
REQ-024 SHALL, on each posedge in SWEEP, zero reg[cnt] and increment cnt.
REQ-025 SHALL go SWEEP->IDLE on the posedge that zeroes index 2^AW-1, so busy is high for exactly 2^AW cycles.
REQ-026 SHALL ignore clear while busy=1: no restart and no extension of the sweep.
REQ-027 SHALL force A=0 and B=0 while busy=1, with bypass disabled.
REQ-028 SHALL discard any write while busy=1 and set wr_drop=1 on the next cycle.
REQ-029 SHALL give clear priority over a write asserted in the same IDLE cycle: the write is discarded and wr_drop=1 on the next cycle.
REQ-030 SHALL otherwise hold wr_drop at 0; wr_drop is high only for a single cycle per dropped write.
REQ-031 SHALL compute cnt increment modulo 2^AW; cnt is not used outside SWEEP.

Reset
REQ-032 SHALL, on posedge with reset=1, zero all registers, set the FSM to IDLE with cnt=0, busy=0 and wr_drop=0.
REQ-033 SHALL give reset priority over clear and write in the same cycle.
REQ-034 SHALL abort an in-progress sweep on reset (reset mid-sweep), leaving all registers zero.

Verification
REQ-035 SHALL cover: after reset, write 64'hDEADBEEF_CAFEF00D to DA=3 -> next cycle SA=3 gives A=64'hDEADBEEF_CAFEF00D and SB=31 gives B=0.
REQ-036 SHALL cover: BYPASS=1, write=1, DA=SA=7, D=64'h1234 -> A=64'h1234 in the same cycle; with BYPASS=0, A keeps its old value until the next cycle.
REQ-037 SHALL cover: write 64'hFFFF to DA=31 with ZERO_REG=1 -> A=0 for SA=31, and wr_drop stays 0.
REQ-038 SHALL cover: clear pulse -> busy=1 for exactly 32 cycles with A=B=0 throughout; afterwards every register reads 0.
REQ-039 SHALL cover: write during busy, and clear+write in the same idle cycle -> the target register is unchanged and wr_drop=1 for exactly one cycle.
REQ-040 SHALL cover: reset asserted at sweep cycle 10 -> next cycle busy=0, wr_drop=0, and all registers read 0.
